spi_sensor_responder: RTL and testbench

- Synthesizable SPI responder modelling the sensor end of the 16-bit sensor link: 16-bit command word in on MOSI, 16-bit result word out on MISO.
- Sits opposite the FPGA SPI master. It is used in the top-level simulation bench and as an on-FPGA loopback target.
- SCLK, CS_b and MOSI are oversampled on the system clock; no SCLK clock domain.
- Result of the command received in frame N is shifted out during frame N+2 (two-frame pipeline).

---
 rtl/spi_sensor_responder.sv | 183 ++++++++++++++++++
 tb/tb_spi_sensor_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sensor_responder.sv
// Sensor-side SPI responder: oversampled SCLK/CS_b/MOSI, 16-bit command in, 16-bit result out two frames later.
// Optional macro SPI_RESP_CHIPID_EN turns register 63 into a read-only chip ID.
module spi_sensor_responder #(
  parameter int         REG_COUNT   = 64,
  parameter logic [7:0] CHIP_ID     = 8'd4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        cs_b,
  input  logic        mosi,
  output logic        miso,
  input  logic [15:0] conv_data,
  output logic        conv_req,
  output logic [5:0]  conv_channel,
  output logic [15:0] frame_count,
  output logic [7:0]  error_count
);

  // state | meaning
  // IDLE  | waiting for cs_b falling edge
  // SHIFT | frame in progress, shifting command in and result out
  // EXEC  | one-cycle decode, register update and pipeline advance
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_EXEC} state_t;

  localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
`ifdef SPI_RESP_CHIPID_EN
  localparam bit RO63 = 1'b1;
`else
  localparam bit RO63 = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_q, cs_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t      state, state_nxt;
  logic        exec;
  logic [4:0]  bit_cnt;
  logic [15:0] cmd, shifter, slot1, slot2, result;
  logic [7:0]  regs [REG_COUNT];
  logic [7:0]  rd_val;
  logic [5:0]  cmd_addr;
  logic        addr_ok, wr_en, clr_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_b};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_rise   = cs_s & ~cs_q;
  assign cs_fall   = ~cs_s & cs_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cs_fall) state_nxt = ST_SHIFT;
      ST_SHIFT: if (cs_rise) state_nxt = (bit_cnt == 5'd16) ? ST_EXEC : ST_IDLE;
      ST_EXEC:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    exec     = (state == ST_EXEC);
    conv_req = exec && (cmd[15:14] == 2'b00);
  end

  // bit_cnt parks at 17 once a frame has overrun, so the cs_b rise flags it as an error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt <= 5'd0;
      cmd     <= 16'h0000;
      shifter <= 16'h0000;
      miso    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            shifter <= slot2;
            miso    <= slot2[15];
            bit_cnt <= 5'd0;
          end
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            if (bit_cnt < 5'd16)  cmd     <= {cmd[14:0], mosi_s};
            if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
          end
          if (sclk_fall) begin
            shifter <= {shifter[14:0], 1'b0};
            miso    <= shifter[14];
          end
          if (cs_rise && bit_cnt != 5'd16) miso <= 1'b0;
        end
        ST_EXEC: miso <= 1'b0;
        default: miso <= 1'b0;
      endcase
    end
  end

  assign cmd_addr = cmd[13:8];
  assign addr_ok  = int'(cmd_addr) < REG_COUNT;
  assign wr_en    = exec && (cmd[15:14] == 2'b10) && addr_ok && !(RO63 && cmd_addr == 6'd63);
  assign clr_en   = exec && (cmd == 16'h6A00);

  always_comb begin
    rd_val = 8'h00;
    if (addr_ok) rd_val = regs[cmd_addr[AW-1:0]];
    if (RO63 && cmd_addr == 6'd63) rd_val = CHIP_ID;
  end

  always_comb begin
    result = 16'hFFFF;
    case (cmd[15:14])
      2'b00: result = conv_data;
      2'b01: if (cmd == 16'h5500 || cmd == 16'h6A00) result = 16'h0000;
      2'b10: result = {8'hFF, cmd[7:0]};
      2'b11: result = {8'h00, rd_val};
      default: result = 16'hFFFF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= 8'h00;
    end else if (clr_en) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (!(RO63 && i == 63)) regs[i] <= 8'h00;
      end
    end else if (wr_en) begin
      regs[cmd_addr[AW-1:0]] <= cmd[7:0];
    end
  end

  // conv_channel is updated as the frame closes so it is already valid while conv_req is high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot1        <= 16'h0000;
      slot2        <= 16'h0000;
      frame_count  <= 16'h0000;
      error_count  <= 8'h00;
      conv_channel <= 6'd0;
    end else begin
      if (exec) begin
        slot1       <= result;
        slot2       <= slot1;
        frame_count <= frame_count + 16'd1;
      end
      if (state == ST_SHIFT && cs_rise) begin
        if (bit_cnt == 5'd16) begin
          if (cmd[15:14] == 2'b00) conv_channel <= cmd[13:8];
        end else if (error_count != 8'hFF) begin
          error_count <= error_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Scoreboard bench for spi_sensor_responder: a bit-banged SPI master feeds a queue-based reference model,
// and a negedge monitor compares each MISO word and every conv_req pulse against it.
module tb_spi_sensor_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_b = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [15:0] conv_data = 16'h0000;
  logic        conv_req;
  logic [5:0]  conv_channel;
  logic [15:0] frame_count;
  logic [7:0]  error_count;

`ifdef SPI_RESP_CHIPID_EN
  localparam bit TB_RO63 = 1'b1;
`else
  localparam bit TB_RO63 = 1'b0;
`endif
  localparam logic [7:0] TB_CHIP_ID = 8'd4;

  spi_sensor_responder dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_b(cs_b), .mosi(mosi), .miso(miso),
    .conv_data(conv_data), .conv_req(conv_req), .conv_channel(conv_channel),
    .frame_count(frame_count), .error_count(error_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    int          nbits;
  } exp_t;

  exp_t        scb[$];
  logic [5:0]  conv_q[$];
  logic [15:0] pipe[$];
  logic [7:0]  ref_regs [64];
  logic [15:0] m_frames;
  int          m_errs;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) ref_regs[i] = 8'h00;
    pipe = '{16'h0000, 16'h0000};
    m_frames = 16'h0000;
    m_errs = 0;
  endtask

  task automatic model_exec(input logic [15:0] cmd, input logic [15:0] cdata, output logic [15:0] res);
    int r;
    r = int'(cmd[13:8]);
    case (cmd[15:14])
      2'b00: res = cdata;
      2'b01: begin
        if (cmd == 16'h5500) res = 16'h0000;
        else if (cmd == 16'h6A00) begin
          res = 16'h0000;
          for (int i = 0; i < 64; i++) if (!(TB_RO63 && i == 63)) ref_regs[i] = 8'h00;
        end else res = 16'hFFFF;
      end
      2'b10: begin
        if (!(TB_RO63 && r == 63)) ref_regs[r] = cmd[7:0];
        res = {8'hFF, cmd[7:0]};
      end
      default: res = (TB_RO63 && r == 63) ? {8'h00, TB_CHIP_ID} : {8'h00, ref_regs[r]};
    endcase
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] cmd, input int nbits, input logic [15:0] cdata);
    exp_t e;
    logic [15:0] res;
    conv_data = cdata;
    if (nbits == 16) begin
      e.word = pipe.pop_front();
      model_exec(cmd, cdata, res);
      pipe.push_back(res);
      m_frames = m_frames + 16'd1;
      if (cmd[15:14] == 2'b00) conv_q.push_back(cmd[13:8]);
    end else begin
      e.word = pipe[0];
      if (m_errs < 255) m_errs++;
    end
    e.nbits = nbits;
    scb.push_back(e);
    cs_b = 1'b0;
    mosi = cmd[15];
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1;
      wait_clk(6);
      sclk = 1'b0;
      mosi = (i + 1 < 16) ? cmd[14 - i] : 1'b0;
      wait_clk(6);
    end
    cs_b = 1'b1;
    mosi = 1'b0;
    wait_clk(10);
    chk("frame_count", {16'd0, frame_count}, {16'd0, m_frames});
    chk("error_count", {24'd0, error_count}, m_errs);
  endtask

  // Monitor: rebuilds each MISO word from master-side SCLK rises and checks conv_req pulses
  bit          in_frame = 1'b0;
  bit          prev_cs = 1'b1;
  bit          prev_sclk = 1'b0;
  int          nseen = 0;
  logic [15:0] got = 16'h0000;

  always @(negedge clk) begin
    exp_t        e;
    int          k;
    logic [15:0] mask;
    if (!reset) begin
      in_frame = 1'b0;
    end else begin
      if (prev_cs && !cs_b) begin
        in_frame = 1'b1;
        nseen = 0;
        got = 16'h0000;
      end
      if (in_frame && !cs_b && !prev_sclk && sclk) begin
        if (nseen < 16) got[15 - nseen] = miso;
        nseen++;
      end
      if (in_frame && !prev_cs && cs_b) begin
        in_frame = 1'b0;
        if (scb.size() == 0) begin
          chk("scb_underflow", 32'd1, 32'd0);
        end else begin
          e = scb.pop_front();
          k = (e.nbits > 16) ? 16 : e.nbits;
          mask = 16'hFFFF << (16 - k);
          chk("sclk_edges", nseen, e.nbits);
          chk("miso_word", {16'd0, got & mask}, {16'd0, e.word & mask});
        end
      end
      if (conv_req) begin
        if (conv_q.size() == 0) chk("conv_req_unexpected", 32'd1, 32'd0);
        else chk("conv_channel", {26'd0, conv_channel}, {26'd0, conv_q.pop_front()});
      end
    end
    prev_cs = cs_b;
    prev_sclk = sclk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [15:0] cmd;
    int unsigned pick;
    int          nb;

    model_reset();
    wait_clk(4);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_conv_req", {31'd0, conv_req}, 32'd0);
    chk("rst_conv_channel", {26'd0, conv_channel}, 32'd0);
    chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
    chk("rst_error_count", {24'd0, error_count}, 32'd0);
    reset = 1'b1;
    wait_clk(4);

    repeat (3) send_frame(16'hC000, 16, 16'h0000);
    send_frame(16'h8A5C, 16, 16'h0000);
    send_frame(16'hCA00, 16, 16'h0000);
    send_frame(16'hC000, 16, 16'h0000);
    send_frame(16'hC000, 16, 16'h0000);
    send_frame(16'h0500, 16, 16'h1234);
    send_frame(16'hC000, 16, 16'h0000);
    send_frame(16'hC000, 16, 16'h0000);
    send_frame(16'hC000, 9, 16'h0000);
    send_frame(16'hC000, 16, 16'h0000);
    send_frame(16'h8133, 17, 16'h0000);
    send_frame(16'hBF77, 16, 16'h0000);
    send_frame(16'hFF00, 16, 16'h0000);
    send_frame(16'h5500, 16, 16'h0000);
    send_frame(16'h6A00, 16, 16'h0000);
    send_frame(16'h4123, 16, 16'h0000);
    send_frame(16'hFF00, 16, 16'h0000);
    send_frame(16'hCA00, 16, 16'h0000);

    for (int i = 0; i < 60; i++) begin
      r = $urandom();
      pick = $urandom_range(0, 7);
      case (pick)
        0, 1:    cmd = {2'b00, r[13:0]};
        2:       cmd = {2'b10, r[13:0]};
        3, 4:    cmd = {2'b11, r[13:0]};
        5:       cmd = 16'h5500;
        6:       cmd = 16'h6A00;
        default: cmd = {2'b01, r[13:0]};
      endcase
      pick = $urandom_range(0, 9);
      nb = (pick == 0) ? int'($urandom_range(1, 15)) : ((pick == 1) ? 17 : 16);
      send_frame(cmd, nb, r[31:16]);
    end

    for (int i = 0; i < 260; i++) send_frame(16'h0000, 1, 16'h0000);

    cs_b = 1'b0;
    mosi = 1'b1;
    wait_clk(6);
    for (int i = 0; i < 7; i++) begin
      sclk = 1'b1;
      wait_clk(6);
      sclk = 1'b0;
      mosi = i[0];
      wait_clk(6);
    end
    reset = 1'b0;
    #1;
    chk("midrst_miso", {31'd0, miso}, 32'd0);
    chk("midrst_frame_count", {16'd0, frame_count}, 32'd0);
    chk("midrst_error_count", {24'd0, error_count}, 32'd0);
    chk("midrst_conv_channel", {26'd0, conv_channel}, 32'd0);
    cs_b = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    model_reset();
    wait_clk(4);
    reset = 1'b1;
    wait_clk(4);

    send_frame(16'h8A5C, 16, 16'h0000);
    send_frame(16'hCA00, 16, 16'h0000);
    send_frame(16'hC000, 16, 16'h0000);
    send_frame(16'hC000, 16, 16'h0000);

    wait_clk(10);
    chk("scb_leftover", scb.size(), 32'd0);
    chk("conv_leftover", conv_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
